// File: rtl/decompressor.sv
// Sparse-activation decompressor: fetches compressed words one request at a time
// and expands each (header mask + packed nonzeros) into a dense FIFO packet.

module decompressor_lane #(
    parameter int N  = 7,
    parameter int CW = 3
) (
    input  logic                en,
    input  logic [CW-1:0]       rank,
    input  logic [N-1:0][7:0]   vals,
    output logic [7:0]          elem
);
    // rank is the count of set mask bits below this lane, i.e. which packed byte it owns
    always_comb begin
        elem = 8'h00;
        if (en) begin
            for (int j = 0; j < N; j++) begin
                if (rank == CW'(j)) elem = vals[j];
            end
        end
    end
endmodule

module decompressor #(
    parameter int MEM_BANDWIDTH          = 8,
    parameter int DECOMRPESS_FIFO_PACKET = 4 + (MEM_BANDWIDTH - 1) * 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              global_buffer_req,
    input  logic [MEM_BANDWIDTH*8-1:0]        mem_data,
    input  logic                              mem_data_valid,
    input  logic                              mem_ack,
    input  logic                              start,
    input  logic [1:0]                        layer_type_in,
    output logic                              decompressor_ack,
    output logic                              mem_req,
    output logic [DECOMRPESS_FIFO_PACKET-1:0] decompress_fifo_packet
);
    localparam int N  = MEM_BANDWIDTH - 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {LT_CONV, LT_DEPTHWISE, LT_FC, LT_RSVD} layer_type_e;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    typedef struct packed {
        logic               valid;
        logic               last;
        layer_type_e        layer_type;
        logic [N-1:0][7:0]  data;
    } pkt_t;

    state_e             state;
    layer_type_e        lt_q;
    pkt_t               pkt;

    logic [7:0]         hdr;
    logic [N-1:0]       mask;
    logic               hdr_last;
    logic [N-1:0][7:0]  vals;
    logic [N-1:0][CW-1:0] rank;
    logic [N-1:0][7:0]  dense;
    logic               accept;
    logic               take;

    assign hdr      = mem_data[7:0];
    assign mask     = hdr[N-1:0];
    assign hdr_last = hdr[7];
    assign vals     = mem_data[MEM_BANDWIDTH*8-1:8];

    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            rank[i] = acc;
            acc     = acc + CW'(mask[i]);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        decompressor_lane #(.N(N), .CW(CW)) u_lane (
            .en   (mask[i]),
            .rank (rank[i]),
            .vals (vals),
            .elem (dense[i])
        );
    end

    // The buffer's claim masks the handshake even if the registered request is still high.
    assign accept = (state == S_REQ) && mem_req && mem_ack && !global_buffer_req;
    assign take   = mem_data_valid && ((state == S_WAIT) || accept);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state            <= S_IDLE;
            lt_q             <= LT_CONV;
            mem_req          <= 1'b0;
            decompressor_ack <= 1'b0;
            pkt              <= '0;
        end else begin
            pkt.valid        <= 1'b0;
            pkt.last         <= 1'b0;
            decompressor_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lt_q    <= layer_type_e'(layer_type_in);
                        state   <= S_REQ;
                        mem_req <= !global_buffer_req;
                    end
                end
                S_REQ: begin
                    if (accept) begin
                        state   <= S_WAIT;
                        mem_req <= 1'b0;
                    end else begin
                        mem_req <= !global_buffer_req;
                    end
                end
                S_WAIT: ;
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
            // Data arriving with the ack is consumed directly, skipping WAIT.
            if (take) begin
                pkt.valid        <= 1'b1;
                pkt.last         <= hdr_last;
                pkt.layer_type   <= lt_q;
                pkt.data         <= dense;
                decompressor_ack <= hdr_last;
                state            <= hdr_last ? S_IDLE : S_REQ;
                mem_req          <= !hdr_last && !global_buffer_req;
            end
        end
    end

    assign decompress_fifo_packet = pkt;
endmodule

// File: tb/tb_decompressor.sv
// Directed + randomized bench for decompressor against a byte-level expansion model.

module tb_decompressor;
    localparam int MB = 8;
    localparam int N  = MB - 1;
    localparam int PW = 4 + 8 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          global_buffer_req = 1'b0;
    logic [MB*8-1:0] mem_data = '0;
    logic          mem_data_valid = 1'b0;
    logic          mem_ack = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    layer_type_in = 2'd0;
    logic          decompressor_ack;
    logic          mem_req;
    logic [PW-1:0] pkt;

    int vectors = 0;
    int miscompares = 0;
    int n_acc = 0;
    logic [63:0] w;

    decompressor #(.MEM_BANDWIDTH(MB)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .global_buffer_req      (global_buffer_req),
        .mem_data               (mem_data),
        .mem_data_valid         (mem_data_valid),
        .mem_ack                (mem_ack),
        .start                  (start),
        .layer_type_in          (layer_type_in),
        .decompressor_ack       (decompressor_ack),
        .mem_req                (mem_req),
        .decompress_fifo_packet (pkt)
    );

    always #5 clk = ~clk;

    // Count accepted memory requests
    always @(posedge clk)
        if (!rst_n && mem_req && mem_ack && !global_buffer_req) n_acc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk the mask, handing out packed bytes in order
    function automatic logic [8*N-1:0] expand(input logic [MB*8-1:0] word);
        logic [8*N-1:0] r;
        int k;
        r = '0;
        k = 1;
        for (int i = 0; i < N; i++) begin
            if (word[i]) begin
                r[8*i +: 8] = word[8*k +: 8];
                k++;
            end
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] exp_pkt(input logic [MB*8-1:0] word, input logic [1:0] lt);
        return {1'b1, word[7], lt, expand(word)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_job(input logic [1:0] lt);
        start = 1'b1;
        layer_type_in = lt;
        tick();
        start = 1'b0;
        layer_type_in = 2'($urandom);
        chk("req_after_start", {63'd0, mem_req}, 64'd1);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_timeout", {63'd0, mem_req}, 64'd1);
    endtask

    task automatic serve_word(input logic [MB*8-1:0] word, input logic [1:0] lt, input int gap);
        wait_req();
        mem_ack = 1'b1;
        mem_data = word;
        mem_data_valid = (gap == 0);
        tick();
        mem_ack = 1'b0;
        if (gap > 0) begin
            chk("req_drop", {63'd0, mem_req}, 64'd0);
            for (int g = 1; g < gap; g++) begin
                tick();
                chk("wait_no_pkt", {63'd0, pkt[PW-1]}, 64'd0);
            end
            mem_data_valid = 1'b1;
            tick();
        end
        mem_data_valid = 1'b0;
        mem_data = {$urandom, $urandom};
        chk("pkt", {4'd0, pkt}, {4'd0, exp_pkt(word, lt)});
        chk("ack", {63'd0, decompressor_ack}, {63'd0, word[7]});
        chk("req_after_data", {63'd0, mem_req}, {63'd0, !word[7]});
        if (word[7]) begin
            tick();
            chk("post_valid", {63'd0, pkt[PW-1]}, 64'd0);
            chk("post_ack", {63'd0, decompressor_ack}, 64'd0);
            chk("post_req", {63'd0, mem_req}, 64'd0);
        end
    endtask

    initial begin
        int a;
        // Reset hold
        repeat (5) tick();
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_ack", {63'd0, decompressor_ack}, 64'd0);
        chk("rst_pkt", {4'd0, pkt}, 64'd0);
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_req", {63'd0, mem_req}, 64'd0);
        end

        // Single last word
        begin_job(2'd2);
        serve_word(64'h7766554433221185, 2'd2, 1);

        // Multi-word job: exactly two requests
        a = n_acc;
        begin_job(2'd1);
        serve_word(64'h070605040302017F, 2'd1, 2);
        serve_word(64'hAABBCCDDEEFF0080, 2'd1, 0);
        chk("multi_reqs", 64'(n_acc - a), 64'd2);

        // Arbitration: acks ignored while the buffer owns the port
        begin_job(2'd0);
        global_buffer_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i % 2 == 0);
            tick();
            chk("arb_req", {63'd0, mem_req}, 64'd0);
            chk("arb_pkt", {63'd0, pkt[PW-1]}, 64'd0);
        end
        global_buffer_req = 1'b0;
        mem_ack = 1'b0;
        tick();
        chk("arb_release", {63'd0, mem_req}, 64'd1);
        serve_word(64'h123456789ABCDE81, 2'd0, 1);

        // Start while busy is ignored
        begin_job(2'd0);
        wait_req();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        start = 1'b1;
        layer_type_in = 2'd1;
        tick();
        start = 1'b0;
        chk("busy_req", {63'd0, mem_req}, 64'd0);
        w = 64'h0102030405060703;
        mem_data = w;
        mem_data_valid = 1'b1;
        tick();
        mem_data_valid = 1'b0;
        chk("busy_pkt", {4'd0, pkt}, {4'd0, exp_pkt(w, 2'd0)});
        serve_word(64'hDEADBEEFCAFE11C5, 2'd0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_no_restart", {63'd0, mem_req}, 64'd0);
        end

        // Reset mid-WAIT clears immediately, including the held packet data
        begin_job(2'd3);
        wait_req();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("midrst_req", {63'd0, mem_req}, 64'd0);
        chk("midrst_ack", {63'd0, decompressor_ack}, 64'd0);
        chk("midrst_pkt", {4'd0, pkt}, 64'd0);
        tick();
        rst_n = 1'b0;
        mem_data = 64'h1122334455667781;
        mem_data_valid = 1'b1;
        tick();
        mem_data_valid = 1'b0;
        chk("midrst_no_pkt", {63'd0, pkt[PW-1]}, 64'd0);
        chk("midrst_no_ack", {63'd0, decompressor_ack}, 64'd0);
        tick();
        chk("midrst_idle", {63'd0, mem_req}, 64'd0);

        // Randomized jobs
        for (int j = 0; j < 10; j++) begin
            logic [1:0] lt;
            int nw;
            lt = 2'($urandom);
            nw = 1 + int'($urandom % 4);
            begin_job(lt);
            for (int k = 0; k < nw; k++) begin
                if ($urandom % 3 == 0) begin
                    global_buffer_req = 1'b1;
                    tick();
                    chk("rand_arb", {63'd0, mem_req}, 64'd0);
                    tick();
                    global_buffer_req = 1'b0;
                    tick();
                end
                w = {$urandom, $urandom};
                w[7] = (k == nw - 1);
                serve_word(w, lt, int'($urandom % 4));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/decompressor.md
# decompressor

Sparse-activation decompressor between the external memory port and the decompress FIFO. On a `start` pulse it fetches compressed words from memory, one outstanding request at a time, and expands each word into a dense FIFO packet. It yields the memory port whenever the global buffer requests it. It stops after a word carrying the last flag and signals completion on `decompressor_ack`.

## Interface
- `MEM_BANDWIDTH`, default 8: memory word width in bytes; legal range 2..8. N = `MEM_BANDWIDTH`-1 is the number of dense elements per word.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset; asynchronous, active-high despite the suffix.
- `global_buffer_req`  in  1  global buffer claims the memory port; blocks new requests.
- `mem_data`  in  `MEM_BANDWIDTH`*8  compressed word; byte k = `mem_data[8k+7:8k]`.
- `mem_data_valid`  in  1  `mem_data` is valid this cycle.
- `mem_ack`  in  1  memory accepted the current `mem_req`.
- `start`  in  1  one-cycle job start from the controller.
- `layer_type_in`  in  2  `LAYER_TYPE` enum: 0 CONV, 1 DEPTHWISE, 2 FC, 3 reserved. Latched at start.
- `decompressor_ack`  out  1  one-cycle pulse when the job completes.
- `mem_req`  out  1  read request to memory.
- `decompress_fifo_packet`  out  `DECOMRPESS_FIFO_PACKET`  fields, MSB to LSB:
  - `valid` (1)
  - `last` (1)
  - `layer_type` (2)
  - `data` (N*8); element i = `data[8i+7:8i]`.

## Operation
- Word format:
  - Byte 0 is the header. Bits [N-1:0] are the nonzero mask. Bit 7 is the last flag. Unused header bits are ignored.
  - Bytes 1..N hold the packed nonzero values in ascending element order.
- Expansion:
  - If mask[i]=1, element i = byte (1 + popcount(mask[i-1:0])).
  - If mask[i]=0, element i = 0x00.
  - Packed bytes beyond popcount(mask) are ignored.
  - The prefix popcount is combinational.
- FSM states:
  - IDLE:
    - `start`=1 latches `layer_type_in` and goes to REQ.
    - `start`=0 stays in IDLE.
  - REQ:
    - `mem_req` = !`global_buffer_req`.
    - If `mem_req` and `mem_ack` are both 1, go to WAIT. If `mem_data_valid` is also 1 in that cycle, the data is consumed as in WAIT instead.
    - `mem_ack` is ignored while `global_buffer_req`=1.
  - WAIT:
    - `mem_req`=0.
    - `mem_data_valid`=1 registers the expanded packet.
    - Then go to IDLE if the header last flag is set, otherwise to REQ.
    - `global_buffer_req` has no effect in this state.
- `start` outside IDLE is ignored.
- `layer_type_in` is sampled only on the accepted `start`.
- The latched `layer_type` does not alter expansion; it only tags the packets.
- The downstream FIFO has no backpressure. It must accept every packet; the rate is at most one packet per memory word.

## Timing
- Reset values:
  - State IDLE, latched layer type 0.
  - `mem_req`=0, `decompressor_ack`=0.
  - Packet all zero, `valid`=0.
- `mem_req` is registered: it rises the cycle after `start` is accepted, provided `global_buffer_req`=0.
- When `global_buffer_req` rises in REQ, `mem_req` drops in the next cycle.
- Packet latency: 1 cycle. A `mem_data_valid` sample at edge t produces `packet.valid`=1 for exactly one cycle starting after edge t.
- Last word:
  - `packet.last`=1 and the `decompressor_ack` pulse occur in the same cycle.
  - `mem_req` stays 0 afterward.
- Non-last word: `mem_req` reasserts in the cycle after the data is sampled.
- Reset mid-job immediately returns the block to the reset values; no pending packet or ack is emitted.

## Test plan
- **Reset:** `rst_n`=1 for 5 cycles -> all outputs 0. Release reset, keep `start`=0 for 10 cycles -> `mem_req` stays 0.
- **Single last word:**
  - Stimulus: `start` with `layer_type_in`=2, `mem_ack`, then `mem_data`=0x77665544_33221185.
  - Required: packet `data` elements = {0x11, 0x00, 0x22, 0x00, 0x00, 0x00, 0x00}.
  - Required: `last`=1, `layer_type`=2, `decompressor_ack` pulses once, `mem_req` returns to 0.
- **Multi-word job:**
  - Stimulus: header 0x7F with bytes 1..7, then header 0x80.
  - Required: first packet equals bytes 1..7, `last`=0.
  - Required: second packet is all-zero data with `last`=1; exactly 2 requests issued.
- **Arbitration:** hold `global_buffer_req`=1 for 4 cycles in REQ while pulsing `mem_ack` -> `mem_req`=0 and no transition. After release, `mem_req`=1 the next cycle.
- **Start while busy:** a second `start` with `layer_type_in`=1 in WAIT -> ignored; packets still tagged with the original type.
- **Reset mid-WAIT:** assert `rst_n` -> outputs clear at once; a later `mem_data_valid` produces no packet.
